// File: rtl/fft_out_reorder_if.sv
// Stream interface for fft_out_reorder: bit-reversed input lanes from topfft,
// natural-order output lanes, and the sticky framing error flag.
// The optional frame counter (FFT_OUT_REORDER_FRAMECNT_EN) adds frame_cnt.
interface fft_out_reorder_if #(
  parameter int NBITS_out = 10
);
  localparam int SW = 2 * NBITS_out;

  // Input side (from topfft)
  logic          in_valid;
  logic          in_start;
  logic [SW-1:0] in0_up;
  logic [SW-1:0] in0_down;
  logic [SW-1:0] in1_up;
  logic [SW-1:0] in1_down;

  // Output side (natural bin order)
  logic          out_valid;
  logic          out_start;
  logic [SW-1:0] out0_up;
  logic [SW-1:0] out0_down;
  logic [SW-1:0] out1_up;
  logic [SW-1:0] out1_down;
  logic          frame_err;

`ifdef FFT_OUT_REORDER_FRAMECNT_EN
  logic [7:0]    frame_cnt;

  modport master (
    output in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
    input  out_valid, out_start, out0_up, out0_down, out1_up, out1_down,
    input  frame_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
    output out_valid, out_start, out0_up, out0_down, out1_up, out1_down,
    output frame_err, frame_cnt
  );
`else
  modport master (
    output in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
    input  out_valid, out_start, out0_up, out0_down, out1_up, out1_down,
    input  frame_err
  );

  modport slave (
    input  in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
    output out_valid, out_start, out0_up, out0_down, out1_up, out1_down,
    output frame_err
  );
`endif

endinterface

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: converts the 4-lane bit-reversed output of a 128-point
// topfft into natural bin order, 4 samples per clock, using two frame banks
// (one filling while the other drains) so back-to-back frames stream gaplessly.
// Optional feature macro: FFT_OUT_REORDER_FRAMECNT_EN adds an 8-bit frame_cnt
// output that counts emitted frames.
module fft_out_reorder #(
  parameter int NBITS_out = 10,
  parameter int N         = 128
) (
  input  logic               clk,
  input  logic               rst,
  fft_out_reorder_if.slave   io
);

  localparam int SW    = 2 * NBITS_out;
  localparam int WORDS = N / 4;
  localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);

  typedef logic [SW-1:0] sample_t;
  typedef enum logic {IDLE, FILL} wstate_e;

  // Reverse the 7-bit bin index.
  function automatic logic [6:0] bitrev7(input logic [6:0] a);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = a[6-i];
    return r;
  endfunction

  // Frame storage: two banks, indexed by the input storage index 4k+j.
  sample_t    mem_q [2][N];

  // Write side state
  wstate_e    state_q;
  logic [4:0] wcnt_q;
  logic       wr_bank_q;
  logic       frame_err_q;

  // Read side state
  logic       drain_q;
  logic [4:0] rcnt_q;
  logic       rd_bank_q;
  logic       out_valid_q;
  logic       out_start_q;
  sample_t    out_q [4];

  // Decoded write controls
  logic       accept;
  logic [4:0] wr_word;
  logic       last_word;
  sample_t    in_lane [4];
  sample_t    rd_lane [4];

  assign in_lane[0] = io.in0_up;
  assign in_lane[1] = io.in0_down;
  assign in_lane[2] = io.in1_up;
  assign in_lane[3] = io.in1_down;

  // Decide whether the current input word is stored, where, and if it closes a frame.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    accept    = 1'b0;
    wr_word   = '0;
    last_word = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.in_valid && io.in_start) accept = 1'b1;
      end
      FILL: begin
        if (io.in_valid) begin
          accept    = 1'b1;
          // A start inside a frame restarts it at word 0 of the same bank.
          wr_word   = io.in_start ? 5'd0 : wcnt_q;
          last_word = !io.in_start && (wcnt_q == LAST_WORD);
        end
      end
      default: ;
    endcase
  end

  // Store the accepted word's four lanes at storage indices 4k..4k+3.
  always_ff @(posedge clk) begin
    // NOTE: the frame banks are deliberately not reset; they are always fully rewritten before being read.
    if (accept) begin
      for (int j = 0; j < 4; j++) begin
        mem_q[wr_bank_q][{wr_word, 2'(j)}] <= in_lane[j];
      end
    end
  end

  // Write FSM: tracks the word count, swaps banks at frame end, flags framing errors.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      wr_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            if (io.in_start) begin
              wcnt_q  <= 5'd1;
              state_q <= FILL;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (io.in_valid) begin
            if (io.in_start) begin
              frame_err_q <= 1'b1;
              wcnt_q      <= 5'd1;
            end else if (last_word) begin
              wcnt_q    <= '0;
              wr_bank_q <= ~wr_bank_q;
              state_q   <= IDLE;
            end else begin
              wcnt_q <= wcnt_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output word m, lane j is bin 4m+j, found at storage index bitrev7(4m+j).
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rd_lane[j] = mem_q[rd_bank_q][bitrev7({rcnt_q, 2'(j)})];
    end
  end

  // Drain sequencer: emits 32 registered words from the read bank after each completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q     <= 1'b0;
      rcnt_q      <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      for (int j = 0; j < 4; j++) out_q[j] <= '0;
    end else begin
      out_valid_q <= drain_q;
      out_start_q <= drain_q && (rcnt_q == 5'd0);
      // Lanes hold their last value while no word is being emitted.
      if (drain_q) begin
        for (int j = 0; j < 4; j++) out_q[j] <= rd_lane[j];
      end
      // A newly completed frame takes over right as the previous drain emits its last word.
      if (last_word) begin
        drain_q   <= 1'b1;
        rcnt_q    <= '0;
        rd_bank_q <= wr_bank_q;
      end else if (drain_q) begin
        if (rcnt_q == LAST_WORD) drain_q <= 1'b0;
        rcnt_q <= rcnt_q + 5'd1;
      end
    end
  end

`ifdef FFT_OUT_REORDER_FRAMECNT_EN
  logic [7:0] frame_cnt_q;

  // Count emitted frames; the new value shows up alongside word 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (out_start_q) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign io.frame_cnt = frame_cnt_q;
`endif

  assign io.out_valid = out_valid_q;
  assign io.out_start = out_start_q;
  assign io.out0_up   = out_q[0];
  assign io.out0_down = out_q[1];
  assign io.out1_up   = out_q[2];
  assign io.out1_down = out_q[3];
  assign io.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder. Frames are held in natural bin
// order; the driver serialises them in bit-reversed order and queues the
// natural-order words with the edge each one must appear after. A monitor
// on the falling edge pops and compares every emitted word.
module tb_fft_out_reorder;

  localparam int NB = 10;
  localparam int SW = 2 * NB;

  typedef logic [SW-1:0] sample_t;

  typedef struct packed {
    logic [3:0][SW-1:0] d;
    logic               start;
    int                 m;
    int                 edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_out_reorder_if #(.NBITS_out(NB)) bus ();

  fft_out_reorder #(.NBITS_out(NB), .N(128)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  exp_t sb[$];
  logic [7:0] fc_model = 8'd0;

  sample_t fa [128];
  sample_t fb [128];
  sample_t fr [128];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [6:0] bitrev7(input int a);
    logic [6:0] v;
    logic [6:0] r;
    v = 7'(a);
    r = {<<{v}};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every emitted word must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0][SW-1:0] got;
    if (!rst) begin
      got = {bus.out1_down, bus.out1_up, bus.out0_down, bus.out0_up};
      if (bus.out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got word %0h start %0b at edge %0d, expected no output",
                   got, bus.out_start, edge_cnt);
        end else begin
          e = sb.pop_front();
          if (got !== e.d || bus.out_start !== e.start || edge_cnt != e.edge_no) begin
            fails++;
            $display("FAIL out_word%0d: got %0h start %0b edge %0d, expected %0h start %0b edge %0d",
                     e.m, got, bus.out_start, edge_cnt, e.d, e.start, e.edge_no);
          end
`ifdef FFT_OUT_REORDER_FRAMECNT_EN
          if (e.m == 0) fc_model = fc_model + 8'd1;
          if (e.m == 1) begin
            tests++;
            if (bus.frame_cnt !== fc_model) begin
              fails++;
              $display("FAIL frame_cnt: got %0d expected %0d", bus.frame_cnt, fc_model);
            end
          end
`endif
        end
      end else if (sb.size() != 0 && sb[0].edge_no <= edge_cnt) begin
        tests++;
        fails++;
        e = sb.pop_front();
        $display("FAIL missing_out%0d: got out_valid 0 expected 1 at edge %0d", e.m, e.edge_no);
      end
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_word(input sample_t f[128], input int k, input logic start);
    bus.in_valid = 1'b1;
    bus.in_start = start;
    bus.in0_up   = f[bitrev7(4*k + 0)];
    bus.in0_down = f[bitrev7(4*k + 1)];
    bus.in1_up   = f[bitrev7(4*k + 2)];
    bus.in1_down = f[bitrev7(4*k + 3)];
  endtask

  // gap: 0 = contiguous, 1 = idle after every word, 2 = random idles.
  task automatic send_frame(input sample_t f[128], input int gap);
    exp_t e;
    int   t;
    for (int k = 0; k < 32; k++) begin
      if (k > 0 && gap == 1) idle(1);
      if (k > 0 && gap == 2) idle($urandom_range(0, 2));
      drive_word(f, k, k == 0);
      if (k == 31) begin
        t = edge_cnt + 1;
        for (int m = 0; m < 32; m++) begin
          for (int j = 0; j < 4; j++) e.d[j] = f[4*m + j];
          e.start   = (m == 0);
          e.m       = m;
          e.edge_no = t + 1 + m;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic send_partial(input sample_t f[128], input int n);
    for (int k = 0; k < n; k++) begin
      drive_word(f, k, k == 0);
      @(negedge clk);
    end
  endtask

  task automatic rand_frame(output sample_t f[128]);
    for (int b = 0; b < 128; b++) f[b] = SW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_out_start"}, 128'(bus.out_start), 128'd0);
    check({tag, "_lanes"}, 128'({bus.out1_down, bus.out1_up, bus.out0_down, bus.out0_up}), 128'd0);
    check({tag, "_frame_err"}, 128'(bus.frame_err), 128'd0);
`ifdef FFT_OUT_REORDER_FRAMECNT_EN
    check({tag, "_frame_cnt"}, 128'(bus.frame_cnt), 128'd0);
`endif
  endtask

  // Asynchronous reset pulse between edges; pending expected words are lost.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    sb.delete();
    fc_model = 8'd0;
    #1;
    check_reset_outputs("rst_pulse");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in0_up   = '0;
    bus.in0_down = '0;
    bus.in1_up   = '0;
    bus.in1_down = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single frame whose samples carry their bin numbers.
    for (int b = 0; b < 128; b++) begin
      fa[b] = {NB'(b), NB'(b) ^ {NB{1'b1}}};
      fb[b] = {NB'(b + 128), NB'(b + 128) ^ {NB{1'b1}}};
    end
    send_frame(fa, 0);
    idle(40);
    check("single_frame_err", 128'(bus.frame_err), 128'd0);

    // Two frames back to back: 64 contiguous output words.
    send_frame(fa, 0);
    send_frame(fb, 0);
    idle(70);

    // in_valid toggling every cycle.
    send_frame(fa, 1);
    idle(40);

    // Random data with random input gaps, some frames back to back.
    for (int i = 0; i < 4; i++) begin
      rand_frame(fr);
      send_frame(fr, 2);
      if (i[0]) idle(40);
    end
    idle(40);
    check("random_frame_err", 128'(bus.frame_err), 128'd0);

    // Abort at word 10 by a new start; only the full frame comes out.
    rand_frame(fr);
    send_partial(fr, 10);
    send_frame(fa, 0);
    idle(40);
    check("abort_frame_err", 128'(bus.frame_err), 128'd1);
    rand_frame(fr);
    send_frame(fr, 0);
    idle(40);
    check("abort_frame_err_sticky", 128'(bus.frame_err), 128'd1);

    // Reset in the middle of a drain, then silence, then a normal frame.
    rand_frame(fr);
    send_frame(fr, 0);
    idle(0);
    repeat (16) @(posedge clk);
    do_reset();
    idle(45);
    check("post_reset_frame_err", 128'(bus.frame_err), 128'd0);
    send_frame(fb, 0);
    idle(40);

    // Word without a start while idle is dropped and flags an error.
    rand_frame(fr);
    drive_word(fr, 3, 1'b0);
    @(negedge clk);
    idle(40);
    check("idle_drop_frame_err", 128'(bus.frame_err), 128'd1);
    send_frame(fa, 2);
    idle(40);

`ifdef FFT_OUT_REORDER_FRAMECNT_EN
    // 257 frames: the counter wraps back to 1.
    do_reset();
    send_frame(fa, 0);
    idle(40);
    check("frame_cnt_first", 128'(bus.frame_cnt), 128'd1);
    for (int i = 1; i < 257; i++) begin
      rand_frame(fr);
      send_frame(fr, 0);
    end
    idle(40);
    check("frame_cnt_wrap", 128'(bus.frame_cnt), 128'd1);
`endif

    // Bounded wait for any outstanding expected words.
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
